// File: rtl/beta_pkg.sv
// Shared encodings for the Beta multi-cycle control unit:
// opcodes, mux selects, FSM states and the decoded-instruction bundle.
package beta_pkg;

   localparam logic [5:0] OP_LD   = 6'b011000;
   localparam logic [5:0] OP_ST   = 6'b011001;
   localparam logic [5:0] OP_JMP  = 6'b011011;
   localparam logic [5:0] OP_BEQ  = 6'b011101;
   localparam logic [5:0] OP_BNE  = 6'b011110;
   localparam logic [5:0] OP_LDR  = 6'b011111;
   localparam logic [1:0] CLS_OP  = 2'b10;
   localparam logic [1:0] CLS_OPC = 2'b11;
   localparam logic [5:0] ALU_ADD = 6'b100000;

   localparam logic [2:0] PCSEL_INC   = 3'd0;
   localparam logic [2:0] PCSEL_BR    = 3'd1;
   localparam logic [2:0] PCSEL_JMP   = 3'd2;
   localparam logic [2:0] PCSEL_ILLOP = 3'd3;
   localparam logic [2:0] PCSEL_XADR  = 3'd4;

   localparam logic [1:0] WDSEL_PC  = 2'd0;
   localparam logic [1:0] WDSEL_ALU = 2'd1;
   localparam logic [1:0] WDSEL_MEM = 2'd2;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_TRAP
   } cu_state_t;

   typedef enum logic [3:0] {
      C_ILL,
      C_OP,
      C_OPC,
      C_LD,
      C_ST,
      C_JMP,
      C_BEQ,
      C_BNE,
      C_LDR
   } op_class_t;

   typedef struct packed {
      op_class_t  cls;
      logic       is_md;
      logic       mem;
      logic [5:0] alufn;
      logic       asel;
      logic       bsel;
      logic       ra2sel;
      logic [1:0] wdsel;
      logic       werf;
   } dec_t;

   // MUL/DIV in both register and constant forms: 10001x / 11001x
   function automatic logic is_muldiv(input logic [5:0] op);
      return op[5] && (op[3:1] == 3'b001);
   endfunction

endpackage

// File: rtl/beta_decode.sv
// Static decode of the registered opcode into instruction class
// and the datapath selects that stay constant for the whole instruction.
module beta_decode
   import beta_pkg::*;
(
   input  logic [5:0] op_i,
   output dec_t       dec_o
);

   always_comb begin
      dec_o     = '0;
      dec_o.cls = C_ILL;
      unique case (1'b1)
         op_i[5:4] == CLS_OP: begin
            dec_o.cls   = C_OP;
            dec_o.alufn = op_i;
            dec_o.is_md = is_muldiv(op_i);
            dec_o.wdsel = WDSEL_ALU;
            dec_o.werf  = 1'b1;
         end
         op_i[5:4] == CLS_OPC: begin
            dec_o.cls   = C_OPC;
            dec_o.alufn = op_i;
            dec_o.is_md = is_muldiv(op_i);
            dec_o.bsel  = 1'b1;
            dec_o.wdsel = WDSEL_ALU;
            dec_o.werf  = 1'b1;
         end
         op_i == OP_LD: begin
            dec_o.cls   = C_LD;
            dec_o.alufn = ALU_ADD;
            dec_o.bsel  = 1'b1;
            dec_o.mem   = 1'b1;
            dec_o.wdsel = WDSEL_MEM;
            dec_o.werf  = 1'b1;
         end
         op_i == OP_ST: begin
            dec_o.cls    = C_ST;
            dec_o.alufn  = ALU_ADD;
            dec_o.bsel   = 1'b1;
            dec_o.ra2sel = 1'b1;
            dec_o.mem    = 1'b1;
         end
         op_i == OP_JMP: begin
            dec_o.cls  = C_JMP;
            dec_o.werf = 1'b1;
         end
         op_i == OP_BEQ: begin
            dec_o.cls  = C_BEQ;
            dec_o.werf = 1'b1;
         end
         op_i == OP_BNE: begin
            dec_o.cls  = C_BNE;
            dec_o.werf = 1'b1;
         end
         op_i == OP_LDR: begin
            dec_o.cls   = C_LDR;
            dec_o.asel  = 1'b1;
            dec_o.mem   = 1'b1;
            dec_o.wdsel = WDSEL_MEM;
            dec_o.werf  = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/beta_mc_cu.sv
// Multi-cycle Beta control unit: FETCH/DECODE/EXEC/MEM/WB/TRAP sequencer
// with memory wait timeout, MUL/DIV handshake and user-mode interrupts.
module beta_mc_cu
   import beta_pkg::*;
#(
   parameter bit MULDIV_MC   = 1'b1,
   parameter int MEM_TIMEOUT = 16,
   parameter int XP_IDX      = 30
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instruction,
   input  logic        mem_ack,
   input  logic        alu_done,
   input  logic        z,
   input  logic        irq,
   input  logic        pc_super,
   output logic        mem_req,
   output logic        ir_load,
   output logic        alu_start,
   output logic [5:0]  ALUFN,
   output logic        ASEL,
   output logic        BSEL,
   output logic        MOE,
   output logic        MWR,
   output logic        RA2SEL,
   output logic        WASEL,
   output logic        WERF,
   output logic [2:0]  PCSEL,
   output logic [1:0]  WDSEL,
   output logic        pc_en,
   output logic        trap
);

   localparam int CW = $clog2(MEM_TIMEOUT + 1);

   cu_state_t     state_q, state_d;
   logic [31:0]   ir_q;
   logic          run_q;
   logic          irq_q, irq_d;
   logic          z_q, z_d;
   logic          started_q, started_d;
   logic [2:0]    cause_q, cause_d;
   logic [CW-1:0] cnt_q, cnt_d;
   dec_t          dec;
   logic          md_wait;
   logic          tmo;
   logic          fetch_entry;
   logic          unused_cfg;

   beta_decode u_dec (
      .op_i  (ir_q[31:26]),
      .dec_o (dec)
   );

   assign md_wait     = MULDIV_MC && dec.is_md;
   assign tmo         = !mem_ack && (cnt_q == CW'(MEM_TIMEOUT - 1));
   assign fetch_entry = (state_d == S_FETCH) && (state_q != S_FETCH || !run_q);
   assign unused_cfg  = ^{ir_q[25:0], 5'(XP_IDX)};

   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      if (!run_q) begin
         state_d = S_FETCH;
      end else begin
         unique case (state_q)
            S_FETCH: begin
               if (irq_q) begin
                  state_d = S_TRAP;
                  cause_d = PCSEL_XADR;
               end else if (mem_ack) begin
                  state_d = S_DECODE;
               end else if (tmo) begin
                  state_d = S_TRAP;
                  cause_d = PCSEL_ILLOP;
               end
            end
            S_DECODE: begin
               if (dec.cls == C_ILL) begin
                  state_d = S_TRAP;
                  cause_d = PCSEL_ILLOP;
               end else begin
                  state_d = S_EXEC;
               end
            end
            S_EXEC: begin
               if (!md_wait || alu_done)
                  state_d = dec.mem ? S_MEM : S_WB;
            end
            S_MEM: begin
               if (mem_ack) begin
                  state_d = S_WB;
               end else if (tmo) begin
                  state_d = S_TRAP;
                  cause_d = PCSEL_ILLOP;
               end
            end
            default: state_d = S_FETCH;
         endcase
      end
   end

   // Wait counter restarts whenever a new state is entered
   always_comb begin
      cnt_d = cnt_q;
      if (state_d != state_q || !run_q)
         cnt_d = '0;
      else if (state_q == S_FETCH || state_q == S_MEM)
         cnt_d = cnt_q + CW'(1);
   end

   assign irq_d     = fetch_entry ? (irq && !pc_super) : irq_q;
   assign z_d       = (state_q == S_EXEC) ? z : z_q;
   assign started_d = (state_q == S_EXEC) && (state_d == S_EXEC);

   always_comb begin
      mem_req   = 1'b0;
      ir_load   = 1'b0;
      alu_start = 1'b0;
      ALUFN     = '0;
      ASEL      = 1'b0;
      BSEL      = 1'b0;
      MOE       = 1'b0;
      MWR       = 1'b0;
      RA2SEL    = 1'b0;
      WASEL     = 1'b0;
      WERF      = 1'b0;
      PCSEL     = PCSEL_INC;
      WDSEL     = WDSEL_PC;
      pc_en     = 1'b0;
      trap      = 1'b0;
      if (run_q) begin
         unique case (state_q)
            S_FETCH: begin
               if (!irq_q) begin
                  mem_req = 1'b1;
                  MOE     = 1'b1;
                  ir_load = mem_ack;
               end
            end
            S_EXEC: begin
               ALUFN     = dec.alufn;
               ASEL      = dec.asel;
               BSEL      = dec.bsel;
               RA2SEL    = dec.ra2sel;
               alu_start = md_wait && !started_q;
            end
            // address and store data stay driven while the bus is busy
            S_MEM: begin
               ALUFN   = dec.alufn;
               ASEL    = dec.asel;
               BSEL    = dec.bsel;
               RA2SEL  = dec.ra2sel;
               mem_req = 1'b1;
               MOE     = (dec.cls != C_ST);
               MWR     = (dec.cls == C_ST);
            end
            S_WB: begin
               pc_en = 1'b1;
               WERF  = dec.werf;
               WDSEL = dec.wdsel;
               unique case (1'b1)
                  dec.cls == C_JMP:         PCSEL = PCSEL_JMP;
                  dec.cls == C_BEQ && z_q:  PCSEL = PCSEL_BR;
                  dec.cls == C_BNE && !z_q: PCSEL = PCSEL_BR;
                  default:                  PCSEL = PCSEL_INC;
               endcase
            end
            S_TRAP: begin
               trap  = 1'b1;
               WERF  = 1'b1;
               WASEL = 1'b1;
               WDSEL = WDSEL_PC;
               pc_en = 1'b1;
               PCSEL = cause_q;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         ir_q      <= '0;
         run_q     <= 1'b0;
         irq_q     <= 1'b0;
         z_q       <= 1'b0;
         started_q <= 1'b0;
         cause_q   <= PCSEL_INC;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         run_q     <= 1'b1;
         irq_q     <= irq_d;
         z_q       <= z_d;
         started_q <= started_d;
         cause_q   <= cause_d;
         cnt_q     <= cnt_d;
         if (ir_load)
            ir_q <= instruction;
      end
   end

endmodule

// File: tb/tb_beta_mc_cu.sv
// Directed-vector bench for beta_mc_cu: inputs change on the falling
// edge, outputs are checked 1 ns later, state commits on the rising edge.
module tb_beta_mc_cu;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] instruction = '0;
   logic        mem_ack = 1'b0;
   logic        alu_done = 1'b0;
   logic        z = 1'b0;
   logic        irq = 1'b0;
   logic        pc_super = 1'b0;
   logic        mem_req, ir_load, alu_start;
   logic [5:0]  ALUFN;
   logic        ASEL, BSEL, MOE, MWR, RA2SEL, WASEL, WERF;
   logic [2:0]  PCSEL;
   logic [1:0]  WDSEL;
   logic        pc_en, trap;

   int total = 0;
   int bad   = 0;

   localparam int          TMO   = 16;
   localparam logic [31:0] I_ADD = 32'h80221800;
   localparam logic [31:0] I_LD  = 32'h60850008;
   localparam logic [31:0] I_ST  = 32'h64000000;
   localparam logic [31:0] I_BEQ = 32'h74000000;
   localparam logic [31:0] I_BNE = 32'h78000000;
   localparam logic [31:0] I_JMP = 32'h6C000000;
   localparam logic [31:0] I_DIV = 32'h8C000000;

   wire [22:0] all_o = {mem_req, ir_load, alu_start, ALUFN, ASEL, BSEL,
                        MOE, MWR, RA2SEL, WASEL, WERF, PCSEL, WDSEL,
                        pc_en, trap};

   always #5 clk = ~clk;

   beta_mc_cu #(
      .MULDIV_MC   (1'b1),
      .MEM_TIMEOUT (TMO),
      .XP_IDX      (30)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instruction (instruction),
      .mem_ack     (mem_ack),
      .alu_done    (alu_done),
      .z           (z),
      .irq         (irq),
      .pc_super    (pc_super),
      .mem_req     (mem_req),
      .ir_load     (ir_load),
      .alu_start   (alu_start),
      .ALUFN       (ALUFN),
      .ASEL        (ASEL),
      .BSEL        (BSEL),
      .MOE         (MOE),
      .MWR         (MWR),
      .RA2SEL      (RA2SEL),
      .WASEL       (WASEL),
      .WERF        (WERF),
      .PCSEL       (PCSEL),
      .WDSEL       (WDSEL),
      .pc_en       (pc_en),
      .trap        (trap)
   );

   // zero-wait fetch; returns with the DECODE cycle's inputs applied
   task automatic issue(input logic [31:0] ins);
      @(negedge clk);
      instruction = ins;
      mem_ack     = 1'b1;
      @(negedge clk);
      instruction = '0;
      mem_ack     = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      total++;
      if (all_o !== '0) begin
         bad++;
         $display("FAIL reset_async outs=%h want 0", all_o);
      end
      repeat (2) @(negedge clk);
      #1;
      total++;
      if (all_o !== '0) begin
         bad++;
         $display("FAIL reset_hold outs=%h want 0", all_o);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      total++;
      if (all_o !== '0) begin
         bad++;
         $display("FAIL reset_release outs=%h want 0", all_o);
      end
   endtask

   task automatic test_add();
      @(negedge clk);
      instruction = I_ADD;
      mem_ack     = 1'b1;
      #1;
      total++;
      if ({mem_req, MOE, ir_load, pc_en} !== 4'b1110) begin
         bad++;
         $display("FAIL add_fetch got=%b want=1110",
                  {mem_req, MOE, ir_load, pc_en});
      end
      @(negedge clk);
      instruction = '0;
      mem_ack     = 1'b0;
      #1;
      total++;
      if (all_o !== '0) begin
         bad++;
         $display("FAIL add_decode outs=%h want 0", all_o);
      end
      @(negedge clk);
      #1;
      total++;
      if ({ALUFN, BSEL, WERF, pc_en} !== {6'b100000, 3'b000}) begin
         bad++;
         $display("FAIL add_exec got=%b want=100000000",
                  {ALUFN, BSEL, WERF, pc_en});
      end
      @(negedge clk);
      #1;
      total++;
      if ({WERF, pc_en, WDSEL, PCSEL, WASEL} !== {2'b11, 2'd1, 3'd0, 1'b0}) begin
         bad++;
         $display("FAIL add_wb got=%b want=11010000",
                  {WERF, pc_en, WDSEL, PCSEL, WASEL});
      end
   endtask

   task automatic test_ld_wait();
      issue(I_LD);
      @(negedge clk);
      #1;
      total++;
      if ({ALUFN, BSEL, ASEL} !== {6'b100000, 2'b10}) begin
         bad++;
         $display("FAIL ld_exec got=%b want=10000010", {ALUFN, BSEL, ASEL});
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         mem_ack = (k == 3);
         #1;
         total++;
         if ({mem_req, MOE, MWR, pc_en} !== 4'b1100) begin
            bad++;
            $display("FAIL ld_mem%0d got=%b want=1100", k,
                     {mem_req, MOE, MWR, pc_en});
         end
      end
      @(negedge clk);
      mem_ack = 1'b0;
      #1;
      total++;
      if ({WDSEL, WERF, pc_en, MOE} !== {2'd2, 3'b110}) begin
         bad++;
         $display("FAIL ld_wb got=%b want=10110", {WDSEL, WERF, pc_en, MOE});
      end
   endtask

   task automatic test_branch();
      logic [31:0] ins_t [5];
      logic        z_t   [5];
      logic [2:0]  pc_t  [5];
      ins_t = '{I_BEQ, I_BEQ, I_BNE, I_BNE, I_JMP};
      z_t   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      pc_t  = '{3'd1, 3'd0, 3'd1, 3'd0, 3'd2};
      for (int i = 0; i < 5; i++) begin
         issue(ins_t[i]);
         @(negedge clk);
         z = z_t[i];
         #1;
         total++;
         if ({mem_req, pc_en, WERF} !== 3'b000) begin
            bad++;
            $display("FAIL br_exec%0d got=%b want=000", i,
                     {mem_req, pc_en, WERF});
         end
         @(negedge clk);
         z = ~z_t[i];
         #1;
         total++;
         if ({PCSEL, WDSEL, WERF, pc_en} !== {pc_t[i], 2'd0, 2'b11}) begin
            bad++;
            $display("FAIL br_wb%0d got=%b want=%b", i,
                     {PCSEL, WDSEL, WERF, pc_en}, {pc_t[i], 4'b0011});
         end
         z = 1'b0;
      end
   endtask

   task automatic test_illop();
      logic [31:0] ill_t [2];
      ill_t = '{32'h00000000, 32'h68000000};
      for (int i = 0; i < 2; i++) begin
         issue(ill_t[i]);
         #1;
         total++;
         if ({trap, pc_en} !== 2'b00) begin
            bad++;
            $display("FAIL ill_decode%0d got=%b want=00", i, {trap, pc_en});
         end
         @(negedge clk);
         #1;
         total++;
         if ({trap, PCSEL, WASEL, WERF, pc_en, WDSEL, mem_req} !==
             {1'b1, 3'd3, 3'b111, 2'd0, 1'b0}) begin
            bad++;
            $display("FAIL ill_trap%0d got=%b want=1011111000", i,
                     {trap, PCSEL, WASEL, WERF, pc_en, WDSEL, mem_req});
         end
         @(negedge clk);
         #1;
         total++;
         if ({trap, mem_req} !== 2'b01) begin
            bad++;
            $display("FAIL ill_after%0d got=%b want=01", i, {trap, mem_req});
         end
      end
   endtask

   task automatic test_st_timeout();
      issue(I_ST);
      @(negedge clk);
      #1;
      total++;
      if ({ALUFN, BSEL, RA2SEL} !== {6'b100000, 2'b11}) begin
         bad++;
         $display("FAIL st_exec got=%b want=10000011", {ALUFN, BSEL, RA2SEL});
      end
      for (int k = 0; k < TMO; k++) begin
         @(negedge clk);
         #1;
         total++;
         if ({mem_req, MWR, MOE, trap} !== 4'b1100) begin
            bad++;
            $display("FAIL st_wait%0d got=%b want=1100", k,
                     {mem_req, MWR, MOE, trap});
         end
      end
      @(negedge clk);
      #1;
      total++;
      if ({trap, MWR, mem_req, PCSEL, WASEL, WERF, pc_en} !==
          {3'b100, 3'd3, 3'b111}) begin
         bad++;
         $display("FAIL st_tmo_trap got=%b want=100011111",
                  {trap, MWR, mem_req, PCSEL, WASEL, WERF, pc_en});
      end
      @(negedge clk);
      #1;
      total++;
      if ({trap, MWR, mem_req} !== 3'b001) begin
         bad++;
         $display("FAIL st_after got=%b want=001", {trap, MWR, mem_req});
      end
   endtask

   task automatic test_ack_at_timeout();
      issue(I_LD);
      @(negedge clk);
      for (int k = 0; k < TMO; k++) begin
         @(negedge clk);
         mem_ack = (k == TMO - 1);
         #1;
         total++;
         if ({mem_req, trap} !== 2'b10) begin
            bad++;
            $display("FAIL edge_wait%0d got=%b want=10", k, {mem_req, trap});
         end
      end
      @(negedge clk);
      mem_ack = 1'b0;
      #1;
      total++;
      if ({trap, pc_en, WDSEL} !== {2'b01, 2'd2}) begin
         bad++;
         $display("FAIL edge_wb got=%b want=0110", {trap, pc_en, WDSEL});
      end
   endtask

   task automatic test_irq();
      issue(I_ADD);
      repeat (2) @(negedge clk);
      #1;
      total++;
      if (pc_en !== 1'b1) begin
         bad++;
         $display("FAIL irq_pre_wb got=%b want=1", pc_en);
      end
      irq = 1'b1;
      @(negedge clk);
      mem_ack = 1'b1;
      instruction = I_BEQ;
      #1;
      total++;
      if ({mem_req, MOE, ir_load, trap} !== 4'b0000) begin
         bad++;
         $display("FAIL irq_fetch got=%b want=0000",
                  {mem_req, MOE, ir_load, trap});
      end
      @(negedge clk);
      mem_ack = 1'b0;
      instruction = '0;
      #1;
      total++;
      if ({trap, PCSEL, WASEL, WDSEL, pc_en} !== {1'b1, 3'd4, 1'b1, 2'd0, 1'b1}) begin
         bad++;
         $display("FAIL irq_trap got=%b want=11001001",
                  {trap, PCSEL, WASEL, WDSEL, pc_en});
      end
      pc_super = 1'b1;
      @(negedge clk);
      instruction = I_ADD;
      mem_ack = 1'b1;
      #1;
      total++;
      if ({mem_req, ir_load, trap} !== 3'b110) begin
         bad++;
         $display("FAIL irq_masked got=%b want=110", {mem_req, ir_load, trap});
      end
      @(negedge clk);
      instruction = '0;
      mem_ack = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      total++;
      if ({pc_en, WDSEL, trap} !== {1'b1, 2'd1, 1'b0}) begin
         bad++;
         $display("FAIL irq_masked_wb got=%b want=1010", {pc_en, WDSEL, trap});
      end
      irq = 1'b0;
      pc_super = 1'b0;
   endtask

   task automatic test_div();
      @(negedge clk);
      instruction = I_DIV;
      mem_ack = 1'b1;
      @(negedge clk);
      instruction = '0;
      mem_ack = 1'b0;
      alu_done = 1'b1;
      @(negedge clk);
      alu_done = 1'b0;
      #1;
      total++;
      if ({alu_start, ALUFN, pc_en} !== {1'b1, 6'b100011, 1'b0}) begin
         bad++;
         $display("FAIL div_start got=%b want=11000110",
                  {alu_start, ALUFN, pc_en});
      end
      for (int k = 1; k < 7; k++) begin
         @(negedge clk);
         #1;
         total++;
         if ({alu_start, pc_en, WERF} !== 3'b000) begin
            bad++;
            $display("FAIL div_wait%0d got=%b want=000", k,
                     {alu_start, pc_en, WERF});
         end
      end
      @(negedge clk);
      alu_done = 1'b1;
      #1;
      total++;
      if ({alu_start, pc_en} !== 2'b00) begin
         bad++;
         $display("FAIL div_done got=%b want=00", {alu_start, pc_en});
      end
      @(negedge clk);
      alu_done = 1'b0;
      #1;
      total++;
      if ({pc_en, WERF, WDSEL, alu_start} !== {2'b11, 2'd1, 1'b0}) begin
         bad++;
         $display("FAIL div_wb got=%b want=11010", {pc_en, WERF, WDSEL, alu_start});
      end
   endtask

   task automatic test_reset_mid_mem();
      issue(I_ST);
      repeat (2) @(negedge clk);
      #1;
      total++;
      if ({mem_req, MWR} !== 2'b11) begin
         bad++;
         $display("FAIL rmm_mem got=%b want=11", {mem_req, MWR});
      end
      #1;
      rst_n = 1'b0;
      #1;
      total++;
      if (all_o !== '0) begin
         bad++;
         $display("FAIL rmm_async outs=%h want 0", all_o);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      total++;
      if ({mem_req, MOE, MWR, trap} !== 4'b1100) begin
         bad++;
         $display("FAIL rmm_refetch got=%b want=1100", {mem_req, MOE, MWR, trap});
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_add();
      test_ld_wait();
      test_branch();
      test_illop();
      test_st_timeout();
      test_ack_at_timeout();
      test_irq();
      test_div();
      test_reset_mid_mem();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/beta_mc_cu.md
# beta_mc_cu

Multi-cycle control unit for the Beta datapath. It replaces single-cycle decode with a registered instruction/state sequencer. It handles OP/OPC ALU classes, LD/ST/LDR, JMP/BEQ/BNE, illegal-opcode traps, user-mode interrupts, variable-latency memory (req/ack) and multi-cycle MUL/DIV. It sits between the instruction/data memory interface and the datapath muxes, register file and PC.

## Interface
- MULDIV_MC, 1: 1 = MUL/DIV (100010, 100011, 110010, 110011) wait for `alu_done`; 0 = single-cycle like other ALU ops.
- MEM_TIMEOUT, 16: max cycles `mem_req` may wait for `mem_ack` before a bus-error trap; ≥2.
- XP_IDX, 30: register index written on trap/interrupt (drives WASEL target; informational to datapath).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- instruction  in  32  memory read data (instruction during FETCH)
- mem_ack  in  1  memory transfer complete, valid with `mem_req`
- alu_done  in  1  multi-cycle ALU result ready
- z  in  1  Reg[Ra]==0, valid in EXEC
- irq  in  1  level interrupt request
- pc_super  in  1  PC[31] supervisor bit
- mem_req  out  1  memory access request
- ir_load  out  1  latch instruction into IR
- alu_start  out  1  one-cycle start pulse for MUL/DIV
- ALUFN  out  6  ALU function
- ASEL, BSEL, MOE, MWR, RA2SEL, WASEL, WERF  out  1 each  datapath controls
- PCSEL  out  3  0 PC+4, 1 branch, 2 JMP, 3 ILLOP, 4 XAdr
- WDSEL  out  2  0 PC+4, 1 ALU, 2 MEM
- pc_en  out  1  PC register update strobe
- trap  out  1  one-cycle pulse on illegal op, bus error or interrupt entry

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP. Reset state FETCH. The internal IR resets to 0.
- Reset values: all 1-bit outputs 0, PCSEL 0, WDSEL 0, ALUFN 0. Outputs are decoded from the registered IR and state only; they are never combinational from `instruction`.
- FETCH:
  - If `irq` && !pc_super on entry: go to TRAP with PCSEL=4; no `mem_req`.
  - Otherwise `mem_req`=1, MOE=1. On `mem_ack`: `ir_load`=1, go to DECODE.
- DECODE: classify IR[31:26].
  - 10xxxx = OP; 11xxxx = OPC; 011000 LD; 011001 ST; 011011 JMP; 011101 BEQ; 011110 BNE; 011111 LDR.
  - Any other opcode goes to TRAP with PCSEL=3.
- EXEC:
  - ALUFN = IR[31:26] for OP/OPC; 100000 (ADD) for LD/ST.
  - BSEL=1 for OPC/LD/ST. RA2SEL=1 only for ST. ASEL=1 only for LDR.
  - If MULDIV_MC and the op is MUL/DIV: `alu_start` pulses on the first EXEC cycle, then hold until `alu_done`. Otherwise 1 cycle.
  - OP/OPC/JMP/BEQ/BNE go to WB. LD/ST/LDR go to MEM.
- MEM:
  - `mem_req`=1. MOE=1 for LD/LDR; MWR=1 for ST.
  - Wait for `mem_ack`, then go to WB.
- WB: one cycle. `pc_en`=1.
  - WERF=1 except ST. WASEL=0.
  - WDSEL: 1 for OP/OPC, 2 for LD/LDR, 0 for JMP/BEQ/BNE.
  - PCSEL: 0, except JMP=2; BEQ=1 if z latched; BNE=1 if !z latched. `z` is latched in EXEC.
  - Go to FETCH.
- TRAP: one cycle. `trap`=1, WERF=1, WASEL=1, WDSEL=0, `pc_en`=1, PCSEL latched cause (3 or 4). Go to FETCH.
- Timeout: a wait counter resets on entry to FETCH/MEM. If it reaches MEM_TIMEOUT without `mem_ack`, go to TRAP with PCSEL=3. MWR drops immediately.
- `irq` is sampled only on FETCH entry. Interrupts are masked when pc_super=1.

## Timing
- Zero-wait memory (`mem_ack` in the same cycle as `mem_req`), cycles per instruction:
  - OP/OPC/branch/JMP: 4.
  - LD/ST/LDR: 5.
  - MUL/DIV: 4 plus alu_done latency.
  - Trap: 2 from FETCH, 3 from DECODE.
- `mem_ack` without `mem_req` is ignored. `alu_done` outside EXEC is ignored.
- `ack` on exactly the timeout cycle counts as success.
- rst_n low mid-instruction: outputs drop to reset values immediately (async); FETCH on the first edge after release. An interrupted ST leaves no lingering MWR.

## Structure
- Package `beta_pkg`:
  - Opcode constants (OP_LD, OP_ST, OP_JMP, OP_BEQ, OP_BNE, OP_LDR, class masks).
  - PCSEL_* / WDSEL_* encodings.
  - State enum `cu_state_t`.
- Sub-module `beta_decode`: combinational IR → class + static mux controls. The FSM and counter stay in the top.

## Test plan
- ADD R1,R2,R3 (0x80221800), ack same cycle → ALUFN=100000, BSEL=0, WDSEL=1, WERF and pc_en high exactly in cycle 4, PCSEL=0.
- LD R4,8(R5) (0x60850008), data ack after 3 waits → MEM lasts 4 cycles with MOE=1, then WB with WDSEL=2, WERF=1.
- BEQ with z=1, then z=0 → PCSEL=1 then 0 in WB. WDSEL=0, WERF=1 both times.
- Opcode 0x00000000 → TRAP after DECODE: PCSEL=3, WASEL=1, trap pulse 1 cycle. ST never acked → trap at cycle MEM_TIMEOUT=16, MWR low thereafter.
- irq=1 with pc_super=0 at FETCH → PCSEL=4, no `mem_req`. Same with pc_super=1 → normal fetch.
- DIV (100011), MULDIV_MC=1, alu_done after 7 cycles → alu_start one pulse, WB on the cycle after done. Assert rst_n=0 mid-MEM → all outputs 0 asynchronously.
